// File: rtl/sfq_adder_result_checker.sv
// sfq_adder_result_checker: delays golden adder results by LATENCY and scores captured output pulses
module sfq_adder_result_checker #(
  parameter int LATENCY = 4,
  parameter int WARMUP = 20,
  parameter int DRAIN = 20,
  parameter int CNT_W = 16
) (
  input  logic             GCLK_Pad,
  input  logic             rst_Pad,
  input  logic             start,
  input  logic             stop,
  input  logic             stim_valid,
  input  logic [3:0]       stim_a,
  input  logic [3:0]       stim_b,
  input  logic             stim_cin,
  input  logic             cout_Pad,
  input  logic             sum0_Pad,
  input  logic             sum1_Pad,
  input  logic             sum2_Pad,
  input  logic             sum3_Pad,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] spur_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [4:0]       first_err_exp,
  output logic [4:0]       first_err_got,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {S_IDLE, S_WARM, S_CHECK, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic [LATENCY-1:0] dl_v;
  logic [4:0] dl_e [LATENCY];
  logic [CNT_W-1:0] dl_i [LATENCY];
  logic [CNT_W-1:0] idx;
  logic clr, act, acc, lv, hit, spur;
  logic [4:0] got, exp_in;
  assign got = {cout_Pad, sum3_Pad, sum2_Pad, sum1_Pad, sum0_Pad};
  assign exp_in = {1'b0, stim_a} + {1'b0, stim_b} + {4'd0, stim_cin};
  assign clr = start && (state == S_IDLE || state == S_DONE);
  assign act = state == S_CHECK || state == S_DRAIN;
  assign acc = stim_valid && state == S_CHECK;
  assign lv = dl_v[LATENCY-1] && act;
  assign hit = got == dl_e[LATENCY-1];
  assign spur = act && !dl_v[LATENCY-1] && got != 5'd0;
  assign busy = state == S_WARM || act;
  assign done = state == S_DONE;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        state_nx = WARMUP == 0 ? S_CHECK : S_WARM;
        cnt_nx = WARMUP == 0 ? 32'd0 : 32'(WARMUP - 1);
      end
      S_WARM: begin
        state_nx = cnt == 32'd0 ? S_CHECK : S_WARM;
        cnt_nx = cnt == 32'd0 ? 32'd0 : cnt - 32'd1;
      end
      S_CHECK: if (stop) begin
        state_nx = S_DRAIN;
        cnt_nx = 32'(DRAIN - 1);
      end
      S_DRAIN: begin
        state_nx = cnt == 32'd0 ? S_DONE : S_DRAIN;
        cnt_nx = cnt == 32'd0 ? 32'd0 : cnt - 32'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad) begin
      state <= S_IDLE;
      cnt <= 32'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  always_ff @(posedge GCLK_Pad) begin
    if (rst_Pad || clr) begin
      dl_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_e[i] <= 5'd0;
        dl_i[i] <= '0;
      end
      idx <= '0;
      pass_cnt <= '0;
      err_cnt <= '0;
      spur_cnt <= '0;
      first_err_valid <= 1'b0;
      first_err_idx <= '0;
      first_err_exp <= 5'd0;
      first_err_got <= 5'd0;
    end else begin
      dl_v[0] <= acc;
      dl_e[0] <= exp_in;
      dl_i[0] <= idx;
      for (int i = 1; i < LATENCY; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_e[i] <= dl_e[i-1];
        dl_i[i] <= dl_i[i-1];
      end
      if (acc) idx <= idx + CNT_W'(1);
      if (lv && hit && !(&pass_cnt)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (lv && !hit && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
      if (spur && !(&spur_cnt)) spur_cnt <= spur_cnt + CNT_W'(1);
      if (lv && !hit && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_idx <= dl_i[LATENCY-1];
        first_err_exp <= dl_e[LATENCY-1];
        first_err_got <= got;
      end
    end
  end
endmodule

// File: tb/tb_sfq_adder_result_checker.sv
// tb_sfq_adder_result_checker: randomized scoreboard bench for the adder result checker
module tb_sfq_adder_result_checker;
  localparam int LATENCY = 4;
  localparam int WARMUP = 20;
  localparam int DRAIN = 20;
  localparam int CNT_W = 16;
  logic clk = 1'b0;
  logic rst_Pad = 1'b0, start = 1'b0, stop = 1'b0, stim_valid = 1'b0, stim_cin = 1'b0;
  logic [3:0] stim_a = 4'd0, stim_b = 4'd0;
  logic cout_Pad = 1'b0, sum0_Pad = 1'b0, sum1_Pad = 1'b0, sum2_Pad = 1'b0, sum3_Pad = 1'b0;
  logic [CNT_W-1:0] pass_cnt, err_cnt, spur_cnt, first_err_idx;
  logic first_err_valid, busy, done;
  logic [4:0] first_err_exp, first_err_got;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  sfq_adder_result_checker #(.LATENCY(LATENCY), .WARMUP(WARMUP), .DRAIN(DRAIN), .CNT_W(CNT_W)) dut (
    .GCLK_Pad(clk), .rst_Pad(rst_Pad), .start(start), .stop(stop), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .stim_cin(stim_cin), .cout_Pad(cout_Pad),
    .sum0_Pad(sum0_Pad), .sum1_Pad(sum1_Pad), .sum2_Pad(sum2_Pad), .sum3_Pad(sum3_Pad),
    .pass_cnt(pass_cnt), .err_cnt(err_cnt), .spur_cnt(spur_cnt), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got),
    .busy(busy), .done(done)
  );
  typedef struct {int due; logic [4:0] e; logic [CNT_W-1:0] idx;} ent_t;
  ent_t q[$];
  int t = 0;
  int m_mode = 0;
  int m_left = 0;
  logic [CNT_W-1:0] m_pass = '0, m_err = '0, m_spur = '0, m_idx = '0, m_fidx = '0;
  bit m_fev = 1'b0;
  logic [4:0] m_fexp = 5'd0, m_fgot = 5'd0;
  function automatic bit due_next();
    return q.size() > 0 && q[0].due == t + 1;
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
  task automatic model_clear();
    q.delete();
    m_pass = '0; m_err = '0; m_spur = '0; m_idx = '0; m_fidx = '0;
    m_fev = 1'b0; m_fexp = 5'd0; m_fgot = 5'd0;
  endtask
  task automatic step(input bit sv, input logic [3:0] a, input logic [3:0] b, input bit ci,
                      input bit st, input bit sp, input bit fe, input logic [4:0] fv);
    logic [4:0] g;
    bit active;
    g = fe ? fv : (due_next() ? q[0].e : 5'd0);
    stim_valid = sv; stim_a = a; stim_b = b; stim_cin = ci; start = st; stop = sp;
    {cout_Pad, sum3_Pad, sum2_Pad, sum1_Pad, sum0_Pad} = g;
    @(posedge clk);
    t++;
    if (rst_Pad) begin
      model_clear();
      m_mode = 0;
    end else begin
      active = m_mode == 2 || m_mode == 3;
      if (active && q.size() > 0 && q[0].due == t) begin
        if (g == q[0].e) m_pass = sat_inc(m_pass);
        else begin
          m_err = sat_inc(m_err);
          if (!m_fev) begin
            m_fev = 1'b1; m_fidx = q[0].idx; m_fexp = q[0].e; m_fgot = g;
          end
        end
        void'(q.pop_front());
      end else if (active && g != 5'd0) m_spur = sat_inc(m_spur);
      if (sv && m_mode == 2) begin
        q.push_back('{t + LATENCY, 5'(a) + 5'(b) + 5'(ci), m_idx});
        m_idx++;
      end
      if ((m_mode == 0 || m_mode == 4) && st) begin
        model_clear();
        m_mode = WARMUP == 0 ? 2 : 1;
        m_left = WARMUP;
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end else if (m_mode == 2 && sp) begin
        m_mode = 3;
        m_left = DRAIN;
      end else if (m_mode == 3) begin
        m_left--;
        if (m_left == 0) m_mode = 4;
      end
    end
    #1;
  endtask
  task automatic idle_step();
    step(0, 4'd0, 4'd0, 0, 0, 0, 0, 5'd0);
  endtask
  task automatic test_reset();
    rst_Pad = 1'b1;
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'h1F);
    rst_Pad = 1'b0;
    checks++;
    if ({pass_cnt, err_cnt, spur_cnt, first_err_idx} !== '0 || {first_err_valid, first_err_exp, first_err_got, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pass=%0d err=%0d spur=%0d fev=%0b busy=%0b done=%0b expected all 0", pass_cnt, err_cnt, spur_cnt, first_err_valid, busy, done);
    end
  endtask
  task automatic test_warmup();
    step(0, 4'd0, 4'd0, 0, 1, 0, 0, 5'd0);
    for (int i = 0; i < WARMUP; i++) step(1, 4'($urandom), 4'($urandom), 0, 0, 1, 1, 5'b00001);
    checks++;
    if (spur_cnt !== 16'd0 || busy !== 1'b1 || pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL warmup_ignore got spur=%0d busy=%0b pass=%0d err=%0d expected spur=0 busy=1 pass=0 err=0", spur_cnt, busy, pass_cnt, err_cnt);
    end
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'b00001);
    checks++;
    if (spur_cnt !== 16'd1 || spur_cnt !== m_spur) begin
      errors++;
      $display("FAIL check_entry_cycle21 got spur=%0d expected 1 (model %0d)", spur_cnt, m_spur);
    end
  endtask
  task automatic test_pass();
    step(1, 4'hC, 4'hC, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < LATENCY - 1; i++) idle_step();
    checks++;
    if (pass_cnt !== 16'd0) begin
      errors++;
      $display("FAIL pass_early got pass=%0d expected 0", pass_cnt);
    end
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'b11000);
    checks++;
    if (pass_cnt !== 16'd1 || err_cnt !== 16'd0 || pass_cnt !== m_pass) begin
      errors++;
      $display("FAIL pass_c_plus_c got pass=%0d err=%0d expected pass=1 err=0", pass_cnt, err_cnt);
    end
  endtask
  task automatic test_mismatch();
    logic [CNT_W-1:0] idx0;
    idx0 = m_idx;
    step(1, 4'h7, 4'h7, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < LATENCY - 1; i++) idle_step();
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'h0F);
    checks++;
    if (err_cnt !== 16'd1 || first_err_valid !== 1'b1 || first_err_exp !== 5'h0E || first_err_got !== 5'h0F || first_err_idx !== idx0) begin
      errors++;
      $display("FAIL mismatch_record got err=%0d fev=%0b exp=%h got=%h idx=%0d expected err=1 fev=1 exp=0e got=0f idx=%0d", err_cnt, first_err_valid, first_err_exp, first_err_got, first_err_idx, idx0);
    end
    step(1, 4'h3, 4'h1, 1, 0, 0, 0, 5'd0);
    for (int i = 0; i < LATENCY - 1; i++) idle_step();
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'h00);
    checks++;
    if (err_cnt !== 16'd2 || first_err_exp !== 5'h0E || first_err_got !== 5'h0F || first_err_idx !== idx0) begin
      errors++;
      $display("FAIL first_err_hold got err=%0d exp=%h got=%h idx=%0d expected err=2 exp=0e got=0f idx=%0d", err_cnt, first_err_exp, first_err_got, first_err_idx, idx0);
    end
  endtask
  task automatic test_back_to_back();
    logic [CNT_W-1:0] p0;
    p0 = m_pass;
    for (int i = 0; i < 12; i++) step(1, 4'($urandom), 4'($urandom), 1'($urandom), 0, i == 11, 0, 5'd0);
    for (int k = 1; k <= DRAIN; k++) begin
      idle_step();
      if (k == DRAIN - 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL drain_not_done got done=%0b busy=%0b expected done=0 busy=1", done, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_done got done=%0b busy=%0b expected done=1 busy=0", done, busy);
    end
    checks++;
    if (pass_cnt !== p0 + 16'd12 || pass_cnt !== m_pass || err_cnt !== m_err) begin
      errors++;
      $display("FAIL b2b_pass got pass=%0d err=%0d expected pass=%0d err=%0d", pass_cnt, err_cnt, p0 + 16'd12, m_err);
    end
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'h1F);
    checks++;
    if (done !== 1'b1 || spur_cnt !== m_spur || pass_cnt !== m_pass) begin
      errors++;
      $display("FAIL done_hold got done=%0b spur=%0d pass=%0d expected done=1 spur=%0d pass=%0d", done, spur_cnt, pass_cnt, m_spur, m_pass);
    end
  endtask
  task automatic test_spurious();
    step(0, 4'd0, 4'd0, 0, 1, 0, 0, 5'd0);
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd0 || spur_cnt !== 16'd0 || first_err_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got pass=%0d err=%0d spur=%0d fev=%0b busy=%0b expected 0 0 0 0 1", pass_cnt, err_cnt, spur_cnt, first_err_valid, busy);
    end
    for (int i = 0; i < WARMUP; i++) idle_step();
    step(0, 4'd0, 4'd0, 0, 0, 0, 1, 5'b10000);
    checks++;
    if (spur_cnt !== 16'd1 || pass_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL spurious_cout got spur=%0d pass=%0d err=%0d expected spur=1 pass=0 err=0", spur_cnt, pass_cnt, err_cnt);
    end
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1, 4'($urandom), 4'($urandom), 1'($urandom), 0, 0, 0, 5'd0);
    rst_Pad = 1'b1;
    idle_step();
    rst_Pad = 1'b0;
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd0 || spur_cnt !== 16'd0 || first_err_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got pass=%0d err=%0d spur=%0d fev=%0b busy=%0b done=%0b expected all 0", pass_cnt, err_cnt, spur_cnt, first_err_valid, busy, done);
    end
    for (int i = 0; i < LATENCY + 2; i++) step(1, 4'hF, 4'hF, 1, 0, 0, 1, 5'h1F);
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd0 || spur_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_ignore got pass=%0d err=%0d spur=%0d busy=%0b expected 0 0 0 0", pass_cnt, err_cnt, spur_cnt, busy);
    end
  endtask
  task automatic test_random();
    bit fe;
    logic [4:0] fv;
    step(0, 4'd0, 4'd0, 0, 1, 0, 0, 5'd0);
    for (int i = 0; i < WARMUP + 300 + DRAIN; i++) begin
      fe = 1'b0;
      fv = 5'd0;
      if (due_next() && $urandom_range(9) == 0) begin
        fe = 1'b1;
        fv = q[0].e ^ 5'($urandom_range(31, 1));
      end else if (!due_next() && $urandom_range(19) == 0) begin
        fe = 1'b1;
        fv = 5'($urandom_range(31, 1));
      end
      step($urandom_range(2) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
           $urandom_range(15) == 0, i == WARMUP + 299 || (i < WARMUP && $urandom_range(3) == 0), fe, fv);
      checks++;
      if (busy !== (m_mode >= 1 && m_mode <= 3) || done !== (m_mode == 4)) begin
        errors++;
        $display("FAIL rand_phase step=%0d got busy=%0b done=%0b expected model mode %0d", i, busy, done, m_mode);
      end
    end
    checks++;
    if (pass_cnt !== m_pass || err_cnt !== m_err || spur_cnt !== m_spur) begin
      errors++;
      $display("FAIL rand_counts got pass=%0d err=%0d spur=%0d expected pass=%0d err=%0d spur=%0d", pass_cnt, err_cnt, spur_cnt, m_pass, m_err, m_spur);
    end
    checks++;
    if (first_err_valid !== m_fev || (m_fev && (first_err_idx !== m_fidx || first_err_exp !== m_fexp || first_err_got !== m_fgot))) begin
      errors++;
      $display("FAIL rand_first_err got fev=%0b idx=%0d exp=%h got=%h expected fev=%0b idx=%0d exp=%h got=%h", first_err_valid, first_err_idx, first_err_exp, first_err_got, m_fev, m_fidx, m_fexp, m_fgot);
    end
  endtask
  initial begin
    test_reset();
    test_warmup();
    test_pass();
    test_mismatch();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
